// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package riscv_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIfBusy = 2'd1,
    StDBusy  = 2'd2
  } arb_state_e;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  localparam logic [31:0] TimeoutData = 32'hDEADBEEF;

  localparam int unsigned TimeoutCyclesDef = 255;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter for mem_arbiter; flags a transaction that outlives TIMEOUT_CYCLES.
module arb_watchdog
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_expired
);

  logic [31:0] r_cnt;

  // Fires on the TIMEOUT_CYCLES-th busy cycle that has no ack.
  assign o_expired = i_busy & ~i_ack & (r_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_busy || i_ack || o_expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter onto one shared memory port.
// Optional transaction timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_len,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [1:0]  m_len,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        stall,
  output logic        err
);

  arb_state_e  r_state;
  logic        r_m_req, r_m_we;
  logic [31:0] r_m_addr, r_m_wdata;
  logic [1:0]  r_m_len;
  logic        r_if_valid, r_d_valid;
  logic [31:0] r_if_rdata, r_d_rdata;

  logic        w_if_pend, w_d_pend, w_busy, w_timeout, w_done;
  logic        w_grant_d, w_grant_if;
  logic [31:0] w_rdata;

  // A requester still holds its req during its own valid pulse; that is not a new request.
  assign w_if_pend = if_req & ~r_if_valid;
  assign w_d_pend  = d_req & ~r_d_valid;
  assign w_busy    = (r_state != StIdle);
  assign w_done    = w_busy & (m_ack | w_timeout);
  assign w_rdata   = m_ack ? m_rdata : TimeoutData;

  assign w_grant_d  = ((r_state == StIdle) & w_d_pend) |
                      ((r_state == StIfBusy) & w_done & w_d_pend);
  assign w_grant_if = ((r_state == StIdle) & ~w_d_pend & w_if_pend) |
                      ((r_state == StDBusy) & w_done & w_if_pend);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_len    <= LenByte;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;

      if (w_done && (r_state == StIfBusy)) begin
        r_if_rdata <= w_rdata;
        r_if_valid <= 1'b1;
      end
      if (w_done && (r_state == StDBusy)) begin
        if (!r_m_we) r_d_rdata <= w_rdata;
        r_d_valid <= 1'b1;
      end

      if (w_grant_d) begin
        r_state   <= StDBusy;
        r_m_req   <= 1'b1;
        r_m_we    <= d_we;
        r_m_addr  <= d_addr;
        r_m_wdata <= d_wdata;
        r_m_len   <= d_len;
      end else if (w_grant_if) begin
        r_state   <= StIfBusy;
        r_m_req   <= 1'b1;
        r_m_we    <= 1'b0;
        r_m_addr  <= if_addr;
        r_m_wdata <= '0;
        r_m_len   <= LenWord;
      end else if (w_done) begin
        r_state <= StIdle;
        r_m_req <= 1'b0;
      end
    end
  end

  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign m_len    = r_m_len;
  assign if_valid = r_if_valid;
  assign d_valid  = r_d_valid;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;

  assign stall = (if_req & ~r_if_valid) | (d_req & ~r_d_valid);

`ifdef MEM_ARB_TIMEOUT_EN
  logic r_err;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_busy   (w_busy),
    .i_ack    (m_ack),
    .o_expired(w_timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule
